pipe_skid_stage: RTL

- Parametrised, handshaked pipeline register: the successor to the fixed-field stage registers between pipeline stages.
- The payload is one packed bus split into a data part and a control part. The control part is zeroed whenever the stage holds no valid entry, so downstream RegWrite/WDSel-style fields never act on stale values.
- A 2-entry skid buffer keeps in_ready off any combinational path from out_ready.
- Supports stall (freeze), flush (kill), occupancy reporting and a saturating bubble counter.

---
 rtl/pipe_skid_stage.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pipe_skid_stage.sv
// Handshaked pipeline register with a 2-entry skid buffer, stall/flush control,
// control-field zeroing when empty, occupancy report and a saturating bubble counter.
module pipe_skid_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              stall,
   input  logic              flush,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  bubble_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [CNT_W-1:0]  bubble_q, bubble_d;
   logic              push, pop;

   // in_ready depends only on local state, never on out_ready.
   assign in_ready   = (state_q != FULL) & ~stall & ~flush & rst;
   assign out_valid  = (state_q != EMPTY) & ~stall & ~flush;
   assign out_data   = main_data_q;
   assign out_ctrl   = (state_q != EMPTY) ? main_ctrl_q : '0;
   assign occupancy  = state_q;
   assign bubble_cnt = bubble_q;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      if (flush) begin
         state_d     = EMPTY;
         main_data_d = '0;
         main_ctrl_d = '0;
         skid_data_d = '0;
         skid_ctrl_d = '0;
      end else if (!stall) begin
         case (state_q)
            EMPTY: begin
               if (push) begin
                  state_d     = ONE;
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end
            end
            ONE: begin
               if (push && !pop) begin
                  state_d     = FULL;
                  skid_data_d = in_data;
                  skid_ctrl_d = in_ctrl;
               end else if (push && pop) begin
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end else if (pop) begin
                  state_d     = EMPTY;
                  main_ctrl_d = '0;
               end
            end
            FULL: begin
               if (pop) begin
                  state_d     = ONE;
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
                  skid_ctrl_d = '0;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Counts downstream-ready cycles with nothing offered, including stall/flush cycles.
   always_comb begin
      bubble_d = bubble_q;
      if (out_ready && !out_valid && (bubble_q != '1)) begin
         bubble_d = bubble_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= EMPTY;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
         bubble_q    <= '0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         bubble_q    <= bubble_d;
      end
   end

endmodule
